// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and fixed-point rescaling helpers for the FIR datapath
//
// Purpose : default widths for the FIR accelerator plus the round/shift/saturate
//           arithmetic used by the result buffer.
// Contents: FIR_DATA_WIDTH, FIR_OUT_WIDTH, FIR_FRAC_BITS, FIR_DEPTH, CALC_WIDTH,
//           sat_result_t, round_shift(), saturate(), sat_rshift_round().
package fir_pkg;

    localparam int FIR_DATA_WIDTH = 32;
    localparam int FIR_OUT_WIDTH  = 16;
    localparam int FIR_FRAC_BITS  = 15;
    localparam int FIR_DEPTH      = 8;

    // Working width for the helpers. It must exceed DATA_WIDTH+1 so that
    // adding the rounding term to a sign-extended sample can never wrap.
    localparam int CALC_WIDTH = 64;

    typedef struct packed {
        logic [CALC_WIDTH-1:0] value;
        logic                  clipped;
    } sat_result_t;

    // Round half up, then drop frac_bits fractional bits with an arithmetic shift.
    function automatic logic signed [CALC_WIDTH-1:0] round_shift(
        input logic signed [CALC_WIDTH-1:0] x,
        input int                           frac_bits
    );
        logic signed [CALC_WIDTH-1:0] half;
        if (frac_bits == 0) begin
            return x;
        end
        half = CALC_WIDTH'(1) << (frac_bits - 1);
        return (x + half) >>> frac_bits;
    endfunction

    // Clamp x to the signed range of an out_width-bit integer.
    function automatic sat_result_t saturate(
        input logic signed [CALC_WIDTH-1:0] x,
        input int                           out_width
    );
        logic signed [CALC_WIDTH-1:0] hi;
        logic signed [CALC_WIDTH-1:0] lo;
        sat_result_t                  res;
        hi          = (CALC_WIDTH'(1) << (out_width - 1)) - CALC_WIDTH'(1);
        lo          = -(CALC_WIDTH'(1) << (out_width - 1));
        res.value   = x;
        res.clipped = 1'b0;
        if (x > hi) begin
            res.value   = hi;
            res.clipped = 1'b1;
        end else if (x < lo) begin
            res.value   = lo;
            res.clipped = 1'b1;
        end
        return res;
    endfunction

    // Single-shot form returning {value, clipped}; the buffer splits the two
    // halves across pipeline stages but software models use this directly.
    function automatic sat_result_t sat_rshift_round(
        input logic signed [CALC_WIDTH-1:0] x,
        input int                           frac_bits,
        input int                           out_width
    );
        return saturate(round_shift(x, frac_bits), out_width);
    endfunction

endpackage

// File: rtl/fir_result_buffer_if.sv
// rtl/fir_result_buffer_if.sv - sample input, result stream and status bundle of the result buffer
//
// Purpose : groups every non-clock/reset signal of fir_result_buffer.
// Signals : in_valid/in_data (MAC results), out_valid/out_ready/out_data (drained
//           results), count/ovf/sat (status), clr_flags/flush (control pulses).
// Modports: master = sequencer/consumer side, slave = fir_result_buffer.
interface fir_result_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int DEPTH      = 8
);

    logic                       in_valid;
    logic [DATA_WIDTH-1:0]      in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [OUT_WIDTH-1:0]       out_data;
    logic [$clog2(DEPTH):0]     count;
    logic                       ovf;
    logic                       sat;
    logic                       clr_flags;
    logic                       flush;

    modport master (
        output in_valid, in_data, out_ready, clr_flags, flush,
        input  out_valid, out_data, count, ovf, sat
    );

    modport slave (
        input  in_valid, in_data, out_ready, clr_flags, flush,
        output out_valid, out_data, count, ovf, sat
    );

endinterface

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - register-array FIFO with registered head output and flush
//
// Purpose : WIDTH x DEPTH synchronous FIFO. The head entry is presented from a
//           dedicated register so it is glitch-free and holds its last value
//           while the FIFO is empty.
// Ports   : clk, rst (async, active high), flush (clears pointers and count),
//           push/push_data, pop, full, empty, count (0..DEPTH), head.
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_q;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_next;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        full        = (count_q == (AW+1)'(DEPTH));
        empty       = (count_q == '0);
        rd_en       = pop & ~empty & ~flush;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        wr_en       = push & ~flush & (~full | rd_en);
        rd_ptr_next = rd_ptr + AW'(rd_en);
        count_next  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        head_next   = head_q;
        if (count_next != '0) begin
            // The incoming word becomes the head when it lands in the slot the
            // read pointer is about to point at (i.e. the FIFO was or goes empty).
            if (wr_en && (wr_ptr == rd_ptr_next)) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_ptr_next;
            count_q <= count_next;
            head_q  <= head_next;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/fir_result_buffer.sv
// rtl/fir_result_buffer.sv - rescales MAC results to OUT_WIDTH integers and queues them for the core
//
// Purpose : stage 1 rounds and shifts each valid MAC result out of Q(FRAC_BITS);
//           stage 2 saturates it to OUT_WIDTH bits and pushes it into a FIFO that
//           the consumer drains with out_valid/out_ready.
// Ports   : clk, rst (async, active high), bus (fir_result_buffer_if.slave):
//           in_valid/in_data, out_valid/out_ready/out_data, count, ovf (sticky
//           drop), sat (sticky clip), clr_flags, flush.
module fir_result_buffer
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int OUT_WIDTH  = FIR_OUT_WIDTH,
    parameter int FRAC_BITS  = FIR_FRAC_BITS,
    parameter int DEPTH      = FIR_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_result_buffer_if.slave   bus
);

    // Stage 1: rounded and shifted sample, one bit wider than the input so the
    // rounding carry of the largest positive value is kept.
    logic                         s1_valid;
    logic signed [DATA_WIDTH:0]   s1_value;

    sat_result_t                  s2_sat;
    logic                         push;
    logic                         pop;
    logic                         full;
    logic                         empty;
    logic                         drop;
    logic                         clip;
    logic                         ovf_q;
    logic                         sat_q;
    logic                         unused_sat_bits;

    always_comb begin
        s2_sat = saturate(CALC_WIDTH'(s1_value), OUT_WIDTH);
        push   = s1_valid & ~bus.flush;
        pop    = bus.out_ready & ~bus.flush;
        // full implies non-empty, so a requested pop is a real pop here.
        drop   = push & full & ~pop;
        clip   = push & s2_sat.clipped;
    end

    // Above OUT_WIDTH the saturated value is only sign extension.
    assign unused_sat_bits = ^s2_sat.value[CALC_WIDTH-1:OUT_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_value <= '0;
        end else begin
            s1_valid <= bus.in_valid & ~bus.flush;
            if (bus.in_valid) begin
                s1_value <= (DATA_WIDTH+1)'(round_shift(CALC_WIDTH'(signed'(bus.in_data)), FRAC_BITS));
            end
        end
    end

    // Sticky flags: a new event in the same cycle as clr_flags keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~bus.clr_flags) | drop;
            sat_q <= (sat_q & ~bus.clr_flags) | clip;
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .push      (push),
        .push_data (s2_sat.value[OUT_WIDTH-1:0]),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (bus.count),
        .head      (bus.out_data)
    );

    assign bus.out_valid = ~empty;
    assign bus.ovf       = ovf_q;
    assign bus.sat       = sat_q;

endmodule

// File: tb/tb_fir_result_buffer.sv
// tb/tb_fir_result_buffer.sv - self-checking bench for fir_result_buffer
module tb_fir_result_buffer;

    localparam int DW    = 32;
    localparam int OW    = 16;
    localparam int FB    = 15;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_result_buffer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DEPTH)) bus ();

    fir_result_buffer #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .FRAC_BITS  (FB),
        .DEPTH      (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue of integers, the pipeline a single pending sample.
    int     mq[$];
    bit     m_pv;
    longint m_pr;
    bit     m_ovf;
    bit     m_sat;
    int     m_head;

    // round-half-up of x / 2^15 using floor division
    function automatic longint round_q(input longint x);
        longint t;
        t = x + 16384;
        if (t >= 0) return t / 32768;
        return -((-t + 32767) / 32768);
    endfunction

    task automatic model_step();
        bit     do_pop;
        bit     do_write;
        bit     dropped;
        bit     clipped;
        longint r;
        int     v;
        if (rst) begin
            mq.delete();
            m_pv   = 1'b0;
            m_ovf  = 1'b0;
            m_sat  = 1'b0;
            m_head = 0;
        end else begin
            do_pop   = (mq.size() > 0) && bus.out_ready && !bus.flush;
            do_write = 1'b0;
            dropped  = 1'b0;
            clipped  = 1'b0;
            v        = 0;
            if (m_pv && !bus.flush) begin
                r = round_q(m_pr);
                if (r > 32767) begin
                    v = 32767; clipped = 1'b1;
                end else if (r < -32768) begin
                    v = -32768; clipped = 1'b1;
                end else begin
                    v = int'(r);
                end
                if (mq.size() < DEPTH || do_pop) do_write = 1'b1;
                else dropped = 1'b1;
            end
            if (bus.clr_flags) begin
                m_ovf = 1'b0;
                m_sat = 1'b0;
            end
            if (dropped) m_ovf = 1'b1;
            if (clipped) m_sat = 1'b1;
            if (bus.flush) begin
                mq.delete();
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (do_write) mq.push_back(v);
            end
            if (mq.size() > 0) m_head = mq[0];
            m_pv = bus.in_valid && !bus.flush;
            m_pr = longint'($signed(bus.in_data));
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    always @(negedge clk) begin
        chk("m_out_valid", longint'(bus.out_valid), longint'(mq.size() > 0));
        chk("m_count", longint'(bus.count), longint'(mq.size()));
        chk("m_out_data", longint'($signed(bus.out_data)), longint'(m_head));
        chk("m_ovf", longint'(bus.ovf), longint'(m_ovf));
        chk("m_sat", longint'(bus.sat), longint'(m_sat));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit rdy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
    endtask

    function automatic logic [31:0] rand_data();
        int s;
        logic [31:0] ext[4];
        ext = '{32'h7FFFFFFF, 32'h80000000, 32'h3FFFBFFF, 32'hC0004000};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: begin
                s = int'($urandom_range(0, 2097152)) - 1048576;
                return 32'(s);
            end
            2: begin
                s = (int'($urandom_range(0, 200)) - 100) * 32768 + 16384 + int'($urandom_range(0, 2)) - 1;
                return 32'(s);
            end
            default: return ext[$urandom_range(0, 3)];
        endcase
    endfunction

    logic [31:0] r_vals[5];
    int          r_exp[5];
    int          rdy_pct;

    initial begin
        r_vals = '{32'h00008000, 32'h00004000, 32'h00003FFF, 32'hFFFFC000, 32'hFFFFBFFF};
        r_exp  = '{1, 1, 0, 0, -1};
        drive(1'b0, 32'h0, 1'b0);
        bus.clr_flags = 1'b0;
        bus.flush     = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_data", longint'(bus.out_data), 0);
        chk("rst_count", longint'(bus.count), 0);
        chk("rst_ovf", longint'(bus.ovf), 0);
        chk("rst_sat", longint'(bus.sat), 0);

        // Rounding, two-cycle latency
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(1'b1, r_vals[i], 1'b1);
            else drive(1'b0, 32'h0, 1'b1);
            step();
            if (i == 0) chk("lat_not_yet", longint'(bus.out_valid), 0);
            if (i >= 1) begin
                chk("round_valid", longint'(bus.out_valid), 1);
                chk("round_data", longint'($signed(bus.out_data)), longint'(r_exp[i-1]));
            end
        end
        chk("round_sat", longint'(bus.sat), 0);

        // Saturation
        drive(1'b1, 32'h7FFFFFFF, 1'b1); step();
        drive(1'b1, 32'h80000000, 1'b1); step();
        chk("sat_hi", longint'($signed(bus.out_data)), 32767);
        drive(1'b0, 32'h0, 1'b1); step();
        chk("sat_lo", longint'($signed(bus.out_data)), -32768);
        chk("sat_set", longint'(bus.sat), 1);
        bus.clr_flags = 1'b1; step(); bus.clr_flags = 1'b0;
        chk("sat_clr", longint'(bus.sat), 0);

        // Overflow: nine writes into eight slots
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 32'(k << 15), 1'b0); step();
        end
        drive(1'b0, 32'h0, 1'b0); step(); step();
        chk("ovf_count", longint'(bus.count), 8);
        chk("ovf_set", longint'(bus.ovf), 1);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("drain_data", longint'($signed(bus.out_data)), k);
            step();
        end
        bus.out_ready = 1'b0;
        chk("drain_count", longint'(bus.count), 0);
        chk("drain_valid", longint'(bus.out_valid), 0);

        // Flush with five queued and one in flight; ovf still set from above
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'((20 + i) << 15), 1'b0); step();
        end
        chk("pre_flush_count", longint'(bus.count), 5);
        drive(1'b1, 32'(30 << 15), 1'b1);
        bus.flush = 1'b1; step(); bus.flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("flush_count", longint'(bus.count), 0);
        chk("flush_valid", longint'(bus.out_valid), 0);
        chk("flush_ovf", longint'(bus.ovf), 1);
        step();
        chk("flush_pipe_count", longint'(bus.count), 0);
        bus.clr_flags = 1'b1; step(); bus.clr_flags = 1'b0;
        chk("ovf_clr", longint'(bus.ovf), 0);

        // Full plus simultaneous write and pop
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 32'(k << 15), 1'b0); step();
        end
        drive(1'b1, 32'(10 << 15), 1'b0); step();
        drive(1'b0, 32'h0, 1'b1); step();
        bus.out_ready = 1'b0;
        chk("full_pp_count", longint'(bus.count), 8);
        chk("full_pp_ovf", longint'(bus.ovf), 0);
        bus.out_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            chk("full_pp_data", longint'($signed(bus.out_data)), (k == 9) ? 10 : k);
            step();
        end
        bus.out_ready = 1'b0;

        // Asynchronous reset mid-burst
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rand_data(), 1'b0); step();
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", longint'(bus.out_valid), 0);
        chk("arst_out_data", longint'(bus.out_data), 0);
        chk("arst_count", longint'(bus.count), 0);
        chk("arst_ovf", longint'(bus.ovf), 0);
        chk("arst_sat", longint'(bus.sat), 0);
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        step();

        // Randomized traffic with phases of varying drain rate
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) rdy_pct = int'($urandom_range(10, 95));
            drive(($urandom_range(0, 3) != 0), rand_data(), (int'($urandom_range(0, 99)) < rdy_pct));
            bus.flush     = ($urandom_range(0, 63) == 0);
            bus.clr_flags = ($urandom_range(0, 31) == 0);
            step();
        end
        drive(1'b0, 32'h0, 1'b1);
        bus.flush     = 1'b0;
        bus.clr_flags = 1'b0;
        repeat (12) step();
        chk("final_count", longint'(bus.count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
